encode_modrm_sib: RTL
=====================

Name: encode_modrm_sib

Overview:
- Encoder counterpart of the ModR/M+SIB decode path: takes a resolved 32-bit memory operand (base, index, scale, displacement, reg field) and emits the canonical x86 ModR/M, optional SIB and displacement bytes as a byte stream.
- Used by the self-check/replay path and by verification to regenerate instruction bytes.
- The decode side of the front end must round-trip every stream it emits.

Parameters:
- DISP_W, 32, displacement input width (fixed 32-bit addressing mode).

Ports:
- clock  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand request valid
- in_ready  output  1  encoder idle, request accepted when in_valid&in_ready
- in_reg  input  3  ModR/M reg/opcode-extension field
- in_base_valid  input  1  base register present
- in_base  input  3  base GPR code (EAX=000..EDI=111)
- in_index_valid  input  1  index register present
- in_index  input  3  index GPR code
- in_scale  input  2  SIB scale code (00=x1..11=x8)
- in_disp  input  32  signed displacement
- out_valid  output  1  out_byte valid
- out_ready  input  1  downstream accepts byte
- out_byte  output  8  emitted byte
- out_last  output  1  final byte of this operand
- err  output  1  one-cycle pulse: illegal request (index=ESP) dropped

Behaviour:
- Reset (async, reset_n=0): state IDLE, in_ready=1, out_valid=0, out_last=0, out_byte=00h, err=0. All captured fields are cleared. Reset mid-stream abandons the operand; no partial bytes are emitted after release.
- States: IDLE, MODRM, SIB, DISP.
- Acceptance happens in IDLE only. in_ready=1 iff state==IDLE. On accept, all inputs are registered and the encoding is computed from the registered copy. The first byte is presented the cycle after accept (latency 1).
- Illegal request: in_index_valid=1 with in_index=100. It is accepted, err pulses one cycle later, no bytes are emitted, and the state stays IDLE.
- need_sib = in_index_valid | (in_base_valid & in_base==100).
- Displacement size:
  - No base: 4 bytes. Gives mod=00, and either rm=101 (no SIB) or SIB base=101.
  - Else, disp==0 and base!=101 (EBP): 0 bytes, mod=00.
  - Else, disp in [-128,127]: 1 byte, mod=01. This includes EBP with disp 0, which encodes disp8=00h.
  - Else: 4 bytes, mod=10.
- ModR/M byte = {mod, in_reg, rm}:
  - rm=100 if need_sib.
  - rm=101 if no base and no SIB.
  - Otherwise rm=base.
- SIB byte = {scale, index, base}:
  - index field = in_index if index valid, else 100 (none). Scale is forced to 00 when there is no index.
  - base field = 101 when there is no base.
- Sequencing:
  - MODRM → SIB if need_sib, else DISP if disp bytes>0, else IDLE.
  - SIB → DISP or IDLE.
  - DISP emits disp bytes little-endian, least significant first, with a 2-bit byte counter. It returns to IDLE after the last byte.
- Handshake:
  - A byte transfers when out_valid&out_ready.
  - out_byte and out_last hold stable while out_valid=1 and out_ready=0.
  - The state advances only on a transfer.
  - out_last=1 on the final byte only.
- Throughput: one byte per cycle with out_ready held high. On the cycle the last byte transfers, the state returns to IDLE and in_ready=1 in the next cycle, so there is one idle bubble between operands.
- Stream length: min 1 byte, max 6 bytes (ModR/M+SIB+disp32).

Test Plan:
- base=EBX, index=ESI, scale=11, disp=20h, reg=000, out_ready=1 → bytes 44h, F3h, 20h. out_last only on 20h. First byte 1 cycle after accept.
- base=EAX, no index, disp=0, reg=001 → single byte 08h, out_last=1.
- base=EBP, no index, disp=0, reg=000 → 45h, 00h. Then the same with disp=12345678h → 85h, 78h, 56h, 34h, 12h.
- No base, no index, disp=00001000h, reg=010 → 15h, 00h, 10h, 00h, 00h. Then base=ESP, disp=0, reg=000 → 04h, 24h.
- index=ESP (100) valid → err pulses 1 cycle, out_valid stays 0, in_ready returns 1. No base with index=ECX, scale=01, disp=0 → 04h, 4Dh, 00h, 00h, 00h, 00h.
- Backpressure: toggle out_ready randomly during a 6-byte stream → out_byte stable while stalled, no byte lost or duplicated. Then assert reset_n=0 mid-stream → outputs at reset values immediately, in_ready=1 after release.

Source files
------------

// File: rtl/encode_modrm_sib.sv
// encode_modrm_sib: turns a resolved 32-bit memory operand into the canonical
// x86 ModR/M, optional SIB and displacement bytes, emitted one byte per transfer.
//
// state  | meaning
// IDLE   | waiting for a request, in_ready=1
// MODRM  | presenting the ModR/M byte
// SIB    | presenting the SIB byte
// DISP   | presenting displacement bytes, least significant first
module encode_modrm_sib #(
  parameter int DISP_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_reg,
  input  logic              in_base_valid,
  input  logic [2:0]        in_base,
  input  logic              in_index_valid,
  input  logic [2:0]        in_index,
  input  logic [1:0]        in_scale,
  input  logic [DISP_W-1:0] in_disp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_byte,
  output logic              out_last,
  output logic              err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MODRM = 2'd1;
  localparam logic [1:0] S_SIB   = 2'd2;
  localparam logic [1:0] S_DISP  = 2'd3;

  logic [1:0]        r_state;
  logic [1:0]        r_cnt;
  logic              r_err;
  logic [2:0]        r_reg;
  logic              r_base_valid;
  logic [2:0]        r_base;
  logic              r_index_valid;
  logic [2:0]        r_index;
  logic [1:0]        r_scale;
  logic [DISP_W-1:0] r_disp;

  logic       w_accept;
  logic       w_illegal;
  logic       w_xfer;
  logic       w_need_sib;
  logic       w_disp8;
  logic [1:0] w_mod;
  logic [2:0] w_rm;
  logic [2:0] w_dlen;
  logic [7:0] w_modrm;
  logic [7:0] w_sib;
  logic [7:0] w_disp_byte;
  logic       w_disp_last;

  assign w_accept  = in_valid & in_ready;
  assign w_illegal = in_index_valid & (in_index == 3'b100);
  assign w_xfer    = out_valid & out_ready;

  // Encoding is derived purely from the registered operand copy.
  assign w_need_sib = r_index_valid | (r_base_valid & (r_base == 3'b100));
  assign w_disp8    = (r_disp[DISP_W-1:7] == '0) | (r_disp[DISP_W-1:7] == '1);

  // Pick mod and displacement length; EBP with disp 0 must still carry a disp8
  // because mod=00/rm=101 (or SIB base=101) means "no base, disp32".
  always_comb begin
    w_mod  = 2'b00;
    w_dlen = 3'd0;
    if (!r_base_valid) begin
      w_mod  = 2'b00;
      w_dlen = 3'd4;
    end else if ((r_disp == '0) && (r_base != 3'b101)) begin
      w_mod  = 2'b00;
      w_dlen = 3'd0;
    end else if (w_disp8) begin
      w_mod  = 2'b01;
      w_dlen = 3'd1;
    end else begin
      w_mod  = 2'b10;
      w_dlen = 3'd4;
    end
  end

  assign w_rm    = w_need_sib ? 3'b100 : (!r_base_valid ? 3'b101 : r_base);
  assign w_modrm = {w_mod, r_reg, w_rm};
  assign w_sib   = {(r_index_valid ? r_scale : 2'b00),
                    (r_index_valid ? r_index : 3'b100),
                    (r_base_valid  ? r_base  : 3'b101)};
  assign w_disp_byte = r_disp[{r_cnt, 3'b000} +: 8];
  assign w_disp_last = (({1'b0, r_cnt} + 3'd1) == w_dlen);

  // Capture requests, sequence the byte stream and generate the error pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= 2'd0;
      r_err         <= 1'b0;
      r_reg         <= 3'd0;
      r_base_valid  <= 1'b0;
      r_base        <= 3'd0;
      r_index_valid <= 1'b0;
      r_index       <= 3'd0;
      r_scale       <= 2'd0;
      r_disp        <= '0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_reg         <= in_reg;
            r_base_valid  <= in_base_valid;
            r_base        <= in_base;
            r_index_valid <= in_index_valid;
            r_index       <= in_index;
            r_scale       <= in_scale;
            r_disp        <= in_disp;
            r_cnt         <= 2'd0;
            if (w_illegal) begin
              r_err <= 1'b1;
            end else begin
              r_state <= S_MODRM;
            end
          end
        end
        S_MODRM: begin
          if (w_xfer) begin
            if (w_need_sib) begin
              r_state <= S_SIB;
            end else if (w_dlen != 3'd0) begin
              r_state <= S_DISP;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_SIB: begin
          if (w_xfer) begin
            r_state <= (w_dlen != 3'd0) ? S_DISP : S_IDLE;
          end
        end
        default: begin
          if (w_xfer) begin
            if (w_disp_last) begin
              r_state <= S_IDLE;
              r_cnt   <= 2'd0;
            end else begin
              r_cnt <= r_cnt + 2'd1;
            end
          end
        end
      endcase
    end
  end

  // Output byte and last flag are a pure function of state, so they hold while stalled.
  always_comb begin
    out_valid = 1'b0;
    out_byte  = 8'h00;
    out_last  = 1'b0;
    case (r_state)
      S_MODRM: begin
        out_valid = 1'b1;
        out_byte  = w_modrm;
        out_last  = ~w_need_sib & (w_dlen == 3'd0);
      end
      S_SIB: begin
        out_valid = 1'b1;
        out_byte  = w_sib;
        out_last  = (w_dlen == 3'd0);
      end
      S_DISP: begin
        out_valid = 1'b1;
        out_byte  = w_disp_byte;
        out_last  = w_disp_last;
      end
      default: begin
        out_valid = 1'b0;
      end
    endcase
  end

  assign in_ready = (r_state == S_IDLE);
  assign err      = r_err;

endmodule
